// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared types and constants for the ALU sequencer
// Purpose: opcode map, FSM state encoding, decode bundle and instruction builder.
// Ports: none (package).
package alu_sequencer_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_PC_W   = 6;
  localparam int OPC_W      = 4;
  localparam int DEF_INSTR_W = OPC_W + DEF_PC_W;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'b0010;
  localparam logic [OPC_W-1:0] OPC_JZ   = 4'b0011;
  localparam logic [OPC_W-1:0] OPC_JC   = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_JS   = 4'b0101;
  localparam logic [OPC_W-1:0] OPC_OUT  = 4'b0110;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'b0111;
  // ALU instructions are 1ooo; the low three bits become alu_op.
  localparam logic [OPC_W-1:0] OPC_ALU  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_Z      = 2'd1,
    COND_C      = 2'd2,
    COND_S      = 2'd3
  } cond_t;

  typedef struct packed {
    logic  is_alu;
    logic  is_jmp;
    cond_t cond_sel;
    logic  is_ldi;
    logic  is_out;
    logic  is_halt;
  } dec_t;

  function automatic logic [DEF_INSTR_W-1:0] mk_instr(input logic [OPC_W-1:0] opc,
                                                      input logic [DEF_PC_W-1:0] operand);
    return {opc, operand};
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction-memory and ALU bus between sequencer and datapath
// Purpose: groups the imem fetch path and the ALU operand/result path.
// Ports (master = sequencer): imem_addr, alu_a, alu_b, alu_op, alu_cin out;
//                             imem_data, alu_r, alu_zero, alu_carry, alu_sign in.
interface alu_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 6
);
  localparam int INSTR_W = 4 + PC_W;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [2:0]         alu_op;
  logic               alu_cin;
  logic [DATA_W-1:0]  alu_r;
  logic               alu_zero;
  logic               alu_carry;
  logic               alu_sign;

  modport master (
    output imem_addr, alu_a, alu_b, alu_op, alu_cin,
    input  imem_data, alu_r, alu_zero, alu_carry, alu_sign
  );

  modport slave (
    input  imem_addr, alu_a, alu_b, alu_op, alu_cin,
    output imem_data, alu_r, alu_zero, alu_carry, alu_sign
  );
endinterface

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational opcode decoder for the ALU sequencer
// Purpose: maps a 4-bit opcode to instruction class flags and jump condition.
// Ports: opcode in [3:0]; dec out (dec_t: is_alu, is_jmp, cond_sel, is_ldi, is_out, is_halt).
module alu_seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output dec_t             dec
);

  always_comb begin
    dec = '0;
    dec.cond_sel = COND_ALWAYS;
    if (opcode[OPC_W-1]) begin
      dec.is_alu = 1'b1;
    end else begin
      case (opcode)
        OPC_LDI:  dec.is_ldi = 1'b1;
        OPC_JMP:  dec.is_jmp = 1'b1;
        OPC_JZ:   begin dec.is_jmp = 1'b1; dec.cond_sel = COND_Z; end
        OPC_JC:   begin dec.is_jmp = 1'b1; dec.cond_sel = COND_C; end
        OPC_JS:   begin dec.is_jmp = 1'b1; dec.cond_sel = COND_S; end
        OPC_OUT:  dec.is_out = 1'b1;
        OPC_HALT: dec.is_halt = 1'b1;
        default:  dec = dec;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/execute sequencer driving a 4-bit combinational ALU
// Purpose: fetches from a sync-read ROM, keeps PC/ACC/flags, runs ALU ops,
//          immediate loads, conditional jumps and output writes.
// Ports: clk, reset (sync, active-high), start (pulse);
//        bus (alu_sequencer_if.master: imem and ALU signals);
//        out_data/out_valid (OUT result and one-cycle strobe); busy; halted.
// Config: ALU_CIN_CHAIN_EN - when defined, ALU ops drive alu_cin from the carry
//         flag so multi-word arithmetic can chain; otherwise alu_cin is tied 0.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  alu_sequencer_if.master   bus,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              halted
);

  localparam int INSTR_W = OPC_W + PC_W;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] acc;
  logic              zf, cf, sf;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [2:0]        alu_op_q;

  logic [OPC_W-1:0]  opcode;
  logic [PC_W-1:0]   operand;
  logic [PC_W-1:0]   pc_inc;
  dec_t              dec;
  logic              jump_taken;

  assign opcode  = bus.imem_data[INSTR_W-1:PC_W];
  assign operand = bus.imem_data[PC_W-1:0];
  // Natural PC_W-bit overflow gives the wrap from the last address to 0.
  assign pc_inc  = pc + PC_W'(1);

  alu_seq_decode u_decode (
    .opcode (opcode),
    .dec    (dec)
  );

  always_comb begin
    jump_taken = 1'b0;
    case (dec.cond_sel)
      COND_ALWAYS: jump_taken = dec.is_jmp;
      COND_Z:      jump_taken = dec.is_jmp & zf;
      COND_C:      jump_taken = dec.is_jmp & cf;
      COND_S:      jump_taken = dec.is_jmp & sf;
      default:     jump_taken = 1'b0;
    endcase
  end

`ifdef ALU_CIN_CHAIN_EN
  logic alu_cin_q;
  assign bus.alu_cin = alu_cin_q;
`else
  assign bus.alu_cin = 1'b0;
`endif

  assign bus.imem_addr = pc;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      acc       <= '0;
      zf        <= 1'b0;
      cf        <= 1'b0;
      sf        <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
`ifdef ALU_CIN_CHAIN_EN
      alu_cin_q <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            pc     <= '0;
            state  <= ST_FETCH;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        // ROM registers imem_addr here; its word is on imem_data in EXEC.
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          state <= ST_FETCH;
          pc    <= jump_taken ? operand : pc_inc;
          if (dec.is_ldi) acc <= operand[DATA_W-1:0];
          if (dec.is_out) begin
            out_data  <= acc;
            out_valid <= 1'b1;
          end
          if (dec.is_halt) begin
            state  <= ST_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end
          if (dec.is_alu) begin
            alu_a_q  <= acc;
            alu_b_q  <= operand[DATA_W-1:0];
            alu_op_q <= opcode[2:0];
`ifdef ALU_CIN_CHAIN_EN
            alu_cin_q <= cf;
`endif
            state    <= ST_WB;
          end
        end
        // ALU is combinational off the registered operands, so its result is ready now.
        ST_WB: begin
          acc   <= bus.alu_r;
          zf    <= bus.alu_zero;
          cf    <= bus.alu_carry;
          sf    <= bus.alu_sign;
          state <= ST_FETCH;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       halted;

  alu_sequencer_if bus_if ();

  alu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus_if),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  logic [9:0] rom [64];
  always @(posedge clk) bus_if.imem_data <= rom[bus_if.imem_addr];

  logic [4:0] sum;
  always_comb begin
    sum              = {1'b0, bus_if.alu_a} + {1'b0, bus_if.alu_b};
    bus_if.alu_r     = sum[3:0];
    bus_if.alu_carry = sum[4];
    bus_if.alu_zero  = (sum[3:0] == 4'd0);
    bus_if.alu_sign  = sum[3];
  end

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int first_halt;
  logic exp_cin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid) pulses++;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = mk_instr(OPC_HALT, 6'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (!halted && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  task automatic run_jump(input string tag, input logic [5:0] ldi_val, input logic [5:0] b_val,
                          input logic [9:0] jinstr, input logic [5:0] exp_addr);
    clear_rom();
    rom[0] = mk_instr(OPC_LDI, ldi_val);
    rom[1] = mk_instr(OPC_ALU, b_val);
    rom[2] = jinstr;
    pulse_start();
    repeat (7) tick();
    check(tag, 32'(bus_if.imem_addr), 32'(exp_addr));
    wait_halt({tag, "_halt"});
  endtask

  initial begin
    clear_rom();
    tick();
    tick();
    reset = 1'b0;
    check("rst_addr", 32'(bus_if.imem_addr), 32'd0);
    check("rst_alu", 32'({bus_if.alu_a, bus_if.alu_b, bus_if.alu_op, bus_if.alu_cin}), 32'd0);
    check("rst_out", 32'({out_data, out_valid, busy, halted}), 32'd0);

    // Test 1: LDI 5; ADD 3; OUT; HALT
    rom[0] = mk_instr(OPC_LDI, 6'd5);
    rom[1] = mk_instr(OPC_ALU, 6'd3);
    rom[2] = mk_instr(OPC_OUT, 6'd0);
    rom[3] = mk_instr(OPC_HALT, 6'd0);
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    pulses = 0;
    first_halt = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (halted && first_halt == 0) first_halt = c;
    end
    check("t1_halt_cycles", 32'(first_halt), 32'd9);
    check("t1_alu_a", 32'(bus_if.alu_a), 32'd5);
    check("t1_alu_b", 32'(bus_if.alu_b), 32'd3);
    check("t1_alu_op", 32'(bus_if.alu_op), 32'd0);
    check("t1_out_data", 32'(out_data), 32'd8);
    check("t1_pulses", 32'(pulses), 32'd1);
    check("t1_pc", 32'(bus_if.imem_addr), 32'd4);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Test 2: conditional jumps on flags set by the previous ALU op
    run_jump("t2_jz_taken", 6'd13, 6'd3, mk_instr(OPC_JZ, 6'h20), 6'h20);
    run_jump("t2_jz_fall", 6'd1, 6'd3, mk_instr(OPC_JZ, 6'h20), 6'h03);
    run_jump("t2_jc_taken", 6'd13, 6'd3, mk_instr(OPC_JC, 6'h30), 6'h30);
    run_jump("t2_js_taken", 6'd5, 6'd3, mk_instr(OPC_JS, 6'h10), 6'h10);
    run_jump("t2_js_fall", 6'd1, 6'd3, mk_instr(OPC_JS, 6'h10), 6'h03);

    // Test 3: JMP to last address, NOP there wraps PC
    clear_rom();
    rom[0]  = mk_instr(OPC_JMP, 6'h3F);
    rom[63] = mk_instr(OPC_NOP, 6'd0);
    pulse_start();
    tick();
    tick();
    check("t3_jmp_3f", 32'(bus_if.imem_addr), 32'h3F);
    tick();
    tick();
    check("t3_wrap", 32'(bus_if.imem_addr), 32'h00);
    check("t3_busy", 32'(busy), 32'd1);

    // Test 4: reset in WB; start pulse mid-run ignored
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_idle", 32'(dut.state), 32'(ST_IDLE));
    clear_rom();
    rom[0] = mk_instr(OPC_LDI, 6'd13);
    rom[1] = mk_instr(OPC_ALU, 6'd3);
    rom[2] = mk_instr(OPC_LDI, 6'd5);
    rom[3] = mk_instr(OPC_ALU, 6'd3);
    pulse_start();
    for (int c = 1; c <= 9; c++) begin
      if (c == 3 || c == 6) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("t4_in_wb", 32'(dut.state), 32'(ST_WB));
    check("t4_pc_no_restart", 32'(bus_if.imem_addr), 32'd4);
    check("t4_pre_acc", 32'(dut.acc), 32'd5);
    check("t4_pre_flags", 32'({dut.zf, dut.cf, dut.sf}), 32'b110);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_acc", 32'(dut.acc), 32'd0);
    check("t4_flags", 32'({dut.zf, dut.cf, dut.sf}), 32'd0);
    check("t4_state", 32'(dut.state), 32'(ST_IDLE));
    check("t4_outs", 32'({busy, halted, bus_if.imem_addr}), 32'd0);

    // Test 5: carry chaining into the next ALU op
`ifdef ALU_CIN_CHAIN_EN
    exp_cin = 1'b1;
`else
    exp_cin = 1'b0;
`endif
    clear_rom();
    rom[0] = mk_instr(OPC_LDI, 6'd15);
    rom[1] = mk_instr(OPC_ALU, 6'd1);
    rom[2] = mk_instr(OPC_ALU, 6'd2);
    pulse_start();
    repeat (4) tick();
    check("t5_cin_first", 32'(bus_if.alu_cin), 32'd0);
    check("t5_a_first", 32'(bus_if.alu_a), 32'd15);
    repeat (3) tick();
    check("t5_cin_chain", 32'(bus_if.alu_cin), 32'(exp_cin));
    check("t5_a_second", 32'(bus_if.alu_a), 32'd0);
    check("t5_b_second", 32'(bus_if.alu_b), 32'd2);
    wait_halt("t5_halt");
    check("t5_acc", 32'(dut.acc), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
